branch_resolve_unit: RTL

- Next-generation branch decision block for the 64-bit LEGv8 pipeline.
- Resolves B, BL, BR, CBZ, CBNZ and all B.cond conditions in EX against an internal NZCV flag register, and registers the taken/mispredict result for the PC mux and flush logic.
- Keeps a parametrised branch history table (BHT) of saturating counters, giving fetch a taken/not-taken prediction.

---
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// LEGv8 EX-stage branch resolver with NZCV flag register and a saturating-counter BHT.
// Optional macro BRANCH_STATS_EN adds branch / mispredict statistics counters.
module branch_resolve_unit #(
    parameter int ADDR_W    = 64,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              f_pred_taken,
    input  logic              ex_valid,
    input  logic [31:0]       ex_instr,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_pred_taken,
    input  logic              ex_zero,
    input  logic              flags_wr,
    input  logic [3:0]        flags_in,
    output logic [3:0]        flags_q,
    output logic              res_valid,
    output logic              br_taken,
    output logic              is_branch,
    output logic              mispredict,
    output logic              init_done,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(BHT_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] init_idx;
    logic [CTR_W-1:0] bht [BHT_DEPTH];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [10:0]      op;
    logic [3:0]       nzcv;
    logic             cond_hold;
    logic             is_uncond;
    logic             is_cbz;
    logic             is_cbnz;
    logic             is_bcond;
    logic             is_cond;
    logic             taken;
    logic [CTR_W-1:0] ex_ctr;
    logic             bht_we;
    logic [IDX_W-1:0] bht_widx;
    logic [CTR_W-1:0] bht_wdata;

    assign f_idx  = f_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign f_pred_taken = f_valid & init_done & bht[f_idx][CTR_W-1];

    logic unused_bits;
    assign unused_bits = ^{f_pc[ADDR_W-1:IDX_W+2], f_pc[1:0],
                           ex_pc[ADDR_W-1:IDX_W+2], ex_pc[1:0], ex_instr[20:5]};

    // Decode, condition evaluation and the BHT write-port arbitration.
    always_comb begin
        op   = ex_instr[31:21];
        nzcv = flags_wr ? flags_in : flags_q;

        case (ex_instr[3:0])
            4'b0000: cond_hold = nzcv[2];
            4'b0001: cond_hold = !nzcv[2];
            4'b0010: cond_hold = nzcv[1];
            4'b0011: cond_hold = !nzcv[1];
            4'b0100: cond_hold = nzcv[3];
            4'b0101: cond_hold = !nzcv[3];
            4'b0110: cond_hold = nzcv[0];
            4'b0111: cond_hold = !nzcv[0];
            4'b1000: cond_hold = nzcv[1] & !nzcv[2];
            4'b1001: cond_hold = !(nzcv[1] & !nzcv[2]);
            4'b1010: cond_hold = (nzcv[3] == nzcv[0]);
            4'b1011: cond_hold = (nzcv[3] != nzcv[0]);
            4'b1100: cond_hold = !nzcv[2] & (nzcv[3] == nzcv[0]);
            4'b1101: cond_hold = !(!nzcv[2] & (nzcv[3] == nzcv[0]));
            default: cond_hold = 1'b1;
        endcase

        is_uncond = (op[10:5] == 6'b000101) || (op[10:5] == 6'b100101) ||
                    (op == 11'b11010110000);
        is_cbz    = (op[10:3] == 8'b10110100);
        is_cbnz   = (op[10:3] == 8'b10110101);
        is_bcond  = (op[10:3] == 8'b01010100) && !ex_instr[4];
        is_cond   = is_cbz | is_cbnz | is_bcond;
        taken     = is_uncond | (is_cbz & ex_zero) | (is_cbnz & !ex_zero) |
                    (is_bcond & cond_hold);

        // The init sweep owns the single write port; EX training only happens in RUN.
        ex_ctr    = bht[ex_idx];
        bht_we    = 1'b0;
        bht_widx  = init_idx;
        bht_wdata = CTR_WEAK_NT;
        if (state == ST_INIT) begin
            bht_we = 1'b1;
        end else if (ex_valid && is_cond) begin
            bht_we   = 1'b1;
            bht_widx = ex_idx;
            if (taken)
                bht_wdata = (ex_ctr == CTR_MAX) ? ex_ctr : ex_ctr + 1'b1;
            else
                bht_wdata = (ex_ctr == '0) ? ex_ctr : ex_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bht_we)
            bht[bht_widx] <= bht_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            init_idx   <= '0;
            init_done  <= 1'b0;
            flags_q    <= 4'b0000;
            res_valid  <= 1'b0;
            br_taken   <= 1'b0;
            is_branch  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == IDX_LAST) begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
            end
            if (flags_wr)
                flags_q <= flags_in;
            res_valid  <= ex_valid;
            br_taken   <= ex_valid & taken;
            is_branch  <= ex_valid & (is_uncond | is_cond);
            mispredict <= ex_valid & (taken != ex_pred_taken);
        end
    end

`ifdef BRANCH_STATS_EN
    // Counters advance on the same edge that registers the corresponding result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (ex_valid && (is_uncond || is_cond) && (stat_branches != '1))
                stat_branches <= stat_branches + 1'b1;
            if (ex_valid && (taken != ex_pred_taken) && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
